// File: rtl/mac_stream_sink.sv
// Stream-to-TCDM write sink: latches base/length on a start handshake, then
// drains the engine output stream into word writes through a one-entry buffer.
module mac_stream_sink #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned TRANS_WIDTH = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    clear_i,
  input  logic                    req_start_i,
  input  logic [ADDR_WIDTH-1:0]   base_addr_i,
  input  logic [TRANS_WIDTH-1:0]  trans_size_i,
  output logic                    ready_start_o,
  output logic                    done_o,
  output logic [TRANS_WIDTH-1:0]  cnt_o,
  input  logic                    stream_valid_i,
  input  logic [DATA_WIDTH-1:0]   stream_data_i,
  output logic                    stream_ready_o,
  output logic                    tcdm_req_o,
  input  logic                    tcdm_gnt_i,
  output logic [ADDR_WIDTH-1:0]   tcdm_add_o,
  output logic                    tcdm_wen_o,
  output logic [DATA_WIDTH/8-1:0] tcdm_be_o,
  output logic [DATA_WIDTH-1:0]   tcdm_data_o
);

  localparam logic [ADDR_WIDTH-1:0]  ADDR_STEP = ADDR_WIDTH'(DATA_WIDTH / 8);
  localparam logic [TRANS_WIDTH-1:0] ONE       = TRANS_WIDTH'(1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                 state_reg;
  logic [ADDR_WIDTH-1:0]  addr_reg;
  logic [TRANS_WIDTH-1:0] size_reg;
  logic [TRANS_WIDTH-1:0] cnt_reg;
  logic [TRANS_WIDTH-1:0] acc_reg;
  logic                   buf_v_reg;
  logic [DATA_WIDTH-1:0]  buf_d_reg;
  logic                   ready_start_reg;
  logic                   done_reg;

  logic accept;
  logic grant;

  // A full buffer can still take a word in the cycle its current word is granted.
  assign stream_ready_o = (state_reg == RUN) && (acc_reg < size_reg) && (!buf_v_reg || tcdm_gnt_i);
  assign accept         = stream_valid_i && stream_ready_o;
  assign grant          = buf_v_reg && tcdm_gnt_i;

  assign ready_start_o = ready_start_reg;
  assign done_o        = done_reg;
  assign cnt_o         = cnt_reg;
  assign tcdm_req_o    = buf_v_reg;
  assign tcdm_add_o    = addr_reg;
  assign tcdm_data_o   = buf_d_reg;
  assign tcdm_wen_o    = 1'b0;
  assign tcdm_be_o     = '1;

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      state_reg       <= IDLE;
      addr_reg        <= '0;
      size_reg        <= '0;
      cnt_reg         <= '0;
      acc_reg         <= '0;
      buf_v_reg       <= 1'b0;
      buf_d_reg       <= '0;
      ready_start_reg <= 1'b1;
      done_reg        <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          done_reg <= 1'b0;
          if (req_start_i) begin
            addr_reg        <= base_addr_i;
            size_reg        <= trans_size_i;
            cnt_reg         <= '0;
            acc_reg         <= '0;
            buf_v_reg       <= 1'b0;
            ready_start_reg <= 1'b0;
            if (trans_size_i == '0) begin
              state_reg <= DONE;
              done_reg  <= 1'b1;
            end else begin
              state_reg <= RUN;
            end
          end
        end
        RUN: begin
          if (accept) begin
            buf_d_reg <= stream_data_i;
            acc_reg   <= acc_reg + ONE;
          end
          buf_v_reg <= accept || (buf_v_reg && !tcdm_gnt_i);
          if (grant) begin
            addr_reg <= addr_reg + ADDR_STEP;
            cnt_reg  <= cnt_reg + ONE;
            if (cnt_reg + ONE == size_reg) begin
              state_reg <= DONE;
              done_reg  <= 1'b1;
            end
          end
        end
        DONE: begin
          done_reg        <= 1'b0;
          ready_start_reg <= 1'b1;
          state_reg       <= IDLE;
        end
        default: begin
          state_reg       <= IDLE;
          buf_v_reg       <= 1'b0;
          done_reg        <= 1'b0;
          ready_start_reg <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mac_stream_sink.sv
// Bench for mac_stream_sink: directed scenarios plus randomized transfers
// checked against an address/data write-list model.
module tb_mac_stream_sink;

  logic        clk = 1'b0;
  logic        rst_i, clear_i, req_start_i;
  logic [31:0] base_addr_i;
  logic [15:0] trans_size_i;
  logic        ready_start_o, done_o;
  logic [15:0] cnt_o;
  logic        stream_valid_i;
  logic [31:0] stream_data_i;
  logic        stream_ready_o, tcdm_req_o, tcdm_gnt_i;
  logic [31:0] tcdm_add_o;
  logic        tcdm_wen_o;
  logic [3:0]  tcdm_be_o;
  logic [31:0] tcdm_data_o;

  always #5 clk = ~clk;

  mac_stream_sink #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TRANS_WIDTH(16)) dut (
    .clk_i(clk), .rst_i(rst_i), .clear_i(clear_i), .req_start_i(req_start_i),
    .base_addr_i(base_addr_i), .trans_size_i(trans_size_i),
    .ready_start_o(ready_start_o), .done_o(done_o), .cnt_o(cnt_o),
    .stream_valid_i(stream_valid_i), .stream_data_i(stream_data_i), .stream_ready_o(stream_ready_o),
    .tcdm_req_o(tcdm_req_o), .tcdm_gnt_i(tcdm_gnt_i), .tcdm_add_o(tcdm_add_o),
    .tcdm_wen_o(tcdm_wen_o), .tcdm_be_o(tcdm_be_o), .tcdm_data_o(tcdm_data_o)
  );

  int pass_n = 0;
  int total_n = 0;

  // Observations from the last transfer
  logic [31:0] words[$];
  logic [31:0] obs_addr[$];
  logic [31:0] obs_data[$];
  int          obs_cyc[$];
  int          done_n, done_cyc, acc_n, ready_over, unstable, stall_ready;
  logic        start_ready, post_done, post_ready, post_req;
  logic [15:0] post_cnt;

  // Model: word i of a transfer lands at base + 4*i (mod 2^32) carrying the i-th stream word.
  function automatic logic [31:0] exp_addr(input logic [31:0] base, input int i);
    return base + 32'(i * 4);
  endfunction

  task automatic run_xfer(input logic [31:0] base, input int size, input int n_avail,
                          input int vpct, input int gpct, input int stall_lo, input int stall_hi,
                          input bit poke);
    logic pend;
    logic [31:0] pa, pd;
    bit stall;
    words.delete(); obs_addr.delete(); obs_data.delete(); obs_cyc.delete();
    for (int i = 0; i < n_avail; i++) words.push_back($urandom);
    done_n = 0; done_cyc = -1; acc_n = 0; ready_over = 0; unstable = 0; stall_ready = 0;
    pend = 1'b0; pa = '0; pd = '0;
    @(negedge clk);
    req_start_i = 1'b1; base_addr_i = base; trans_size_i = 16'(size);
    stream_valid_i = 1'b0; tcdm_gnt_i = 1'b0;
    #1 start_ready = ready_start_o;
    for (int cyc = 1; cyc <= 300; cyc++) begin
      @(negedge clk);
      req_start_i  = poke && ($urandom_range(1) == 1);
      base_addr_i  = $urandom;
      trans_size_i = 16'($urandom);
      stream_valid_i = (acc_n < n_avail) && ($urandom_range(99) < vpct);
      stream_data_i  = (acc_n < n_avail) ? words[acc_n] : $urandom;
      stall = (cyc >= stall_lo) && (cyc <= stall_hi);
      tcdm_gnt_i = stall ? 1'b0 : ($urandom_range(99) < gpct);
      #1;
      if (pend && (!tcdm_req_o || tcdm_add_o !== pa || tcdm_data_o !== pd)) unstable++;
      if (stall && tcdm_req_o && stream_ready_o) stall_ready++;
      if (acc_n >= size && stream_ready_o) ready_over++;
      if (stream_valid_i && stream_ready_o) acc_n++;
      if (tcdm_req_o && tcdm_gnt_i) begin
        obs_addr.push_back(tcdm_add_o); obs_data.push_back(tcdm_data_o); obs_cyc.push_back(cyc);
      end
      pend = tcdm_req_o && !tcdm_gnt_i; pa = tcdm_add_o; pd = tcdm_data_o;
      if (done_o) begin
        done_n++; done_cyc = cyc;
        break;
      end
    end
    @(negedge clk);
    req_start_i = 1'b0; stream_valid_i = 1'b0; tcdm_gnt_i = 1'b0;
    #1;
    post_done = done_o; post_ready = ready_start_o; post_cnt = cnt_o; post_req = tcdm_req_o;
  endtask

  task automatic test_reset;
    rst_i = 1'b1; clear_i = 1'b0; req_start_i = 1'b0; base_addr_i = '0; trans_size_i = '0;
    stream_valid_i = 1'b0; stream_data_i = '0; tcdm_gnt_i = 1'b0;
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
    #1;
    total_n++; if (ready_start_o !== 1'b1) $display("FAIL reset_ready_start got=%b want=1", ready_start_o); else pass_n++;
    total_n++; if (done_o !== 1'b0) $display("FAIL reset_done got=%b want=0", done_o); else pass_n++;
    total_n++; if (cnt_o !== 16'd0) $display("FAIL reset_cnt got=%0d want=0", cnt_o); else pass_n++;
    total_n++; if (stream_ready_o !== 1'b0) $display("FAIL reset_stream_ready got=%b want=0", stream_ready_o); else pass_n++;
    total_n++; if (tcdm_req_o !== 1'b0) $display("FAIL reset_req got=%b want=0", tcdm_req_o); else pass_n++;
    total_n++; if (tcdm_add_o !== 32'd0) $display("FAIL reset_add got=%h want=0", tcdm_add_o); else pass_n++;
    total_n++; if (tcdm_data_o !== 32'd0) $display("FAIL reset_data got=%h want=0", tcdm_data_o); else pass_n++;
    total_n++; if (tcdm_wen_o !== 1'b0 || tcdm_be_o !== 4'hF)
      $display("FAIL reset_wen_be got=%b/%h want=0/f", tcdm_wen_o, tcdm_be_o); else pass_n++;
    $display("test_reset done");
  endtask

  task automatic test_basic;
    run_xfer(32'h1000, 4, 4, 100, 100, 0, -1, 1'b0);
    total_n++; if (start_ready !== 1'b1) $display("FAIL t1_start_ready got=%b want=1", start_ready); else pass_n++;
    total_n++; if (obs_addr.size() != 4) $display("FAIL t1_write_count got=%0d want=4", obs_addr.size()); else pass_n++;
    for (int i = 0; i < obs_addr.size() && i < 4; i++) begin
      total_n++;
      if (obs_addr[i] !== exp_addr(32'h1000, i) || obs_data[i] !== words[i] || obs_cyc[i] != 2 + i)
        $display("FAIL t1_write%0d got=%h/%h@%0d want=%h/%h@%0d", i, obs_addr[i], obs_data[i], obs_cyc[i],
                 exp_addr(32'h1000, i), words[i], 2 + i);
      else pass_n++;
    end
    total_n++; if (done_n != 1 || obs_cyc.size() != 4 || done_cyc != obs_cyc[obs_cyc.size()-1] + 1)
      $display("FAIL t1_done_timing got=%0d@%0d want=1@last_grant+1", done_n, done_cyc); else pass_n++;
    total_n++; if (post_done !== 1'b0 || post_ready !== 1'b1 || post_cnt !== 16'd4)
      $display("FAIL t1_after_done got=done%b/ready%b/cnt%0d want=0/1/4", post_done, post_ready, post_cnt); else pass_n++;
    $display("test_basic base=00001000 size=4 writes=%0d", obs_addr.size());
  endtask

  task automatic test_stall;
    run_xfer(32'h0000_2400, 3, 3, 100, 100, 2, 4, 1'b0);
    total_n++; if (unstable != 0) $display("FAIL t2_stable got=%0d want=0", unstable); else pass_n++;
    total_n++; if (stall_ready != 0) $display("FAIL t2_stall_ready got=%0d want=0", stall_ready); else pass_n++;
    total_n++; if (obs_addr.size() != 3 || obs_cyc[0] != 5)
      $display("FAIL t2_resume got=%0d writes want=3 first@5", obs_addr.size()); else pass_n++;
    for (int i = 0; i < obs_addr.size() && i < 3; i++) begin
      total_n++;
      if (obs_addr[i] !== exp_addr(32'h2400, i) || obs_data[i] !== words[i])
        $display("FAIL t2_write%0d got=%h/%h want=%h/%h", i, obs_addr[i], obs_data[i], exp_addr(32'h2400, i), words[i]);
      else pass_n++;
    end
    $display("test_stall size=3 writes=%0d", obs_addr.size());
  endtask

  task automatic test_zero;
    run_xfer(32'h5000, 0, 2, 100, 100, 0, -1, 1'b0);
    total_n++; if (obs_addr.size() != 0) $display("FAIL t3_no_writes got=%0d want=0", obs_addr.size()); else pass_n++;
    total_n++; if (done_n != 1 || done_cyc < 1 || done_cyc > 2)
      $display("FAIL t3_done got=%0d@%0d want=1@1..2", done_n, done_cyc); else pass_n++;
    total_n++; if (post_ready !== 1'b1 || post_done !== 1'b0 || post_cnt !== 16'd0)
      $display("FAIL t3_after got=ready%b/done%b/cnt%0d want=1/0/0", post_ready, post_done, post_cnt); else pass_n++;
    $display("test_zero size=0 done_cycle=%0d", done_cyc);
  endtask

  task automatic test_wrap;
    run_xfer(32'hFFFF_FFFC, 2, 2, 100, 80, 0, -1, 1'b0);
    total_n++; if (obs_addr.size() != 2) $display("FAIL t4_count got=%0d want=2", obs_addr.size()); else pass_n++;
    for (int i = 0; i < obs_addr.size() && i < 2; i++) begin
      total_n++;
      if (obs_addr[i] !== exp_addr(32'hFFFF_FFFC, i) || obs_data[i] !== words[i])
        $display("FAIL t4_write%0d got=%h/%h want=%h/%h", i, obs_addr[i], obs_data[i], exp_addr(32'hFFFF_FFFC, i), words[i]);
      else pass_n++;
    end
    $display("test_wrap base=fffffffc writes=%0d", obs_addr.size());
  endtask

  task automatic test_clear_mid;
    int g;
    int seen;
    g = 0; seen = 0;
    @(negedge clk);
    req_start_i = 1'b1; base_addr_i = 32'h2000; trans_size_i = 16'd5;
    stream_valid_i = 1'b0; tcdm_gnt_i = 1'b0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      req_start_i = 1'b0; stream_valid_i = 1'b1; stream_data_i = $urandom; tcdm_gnt_i = 1'b1;
      #1;
      if (tcdm_req_o && tcdm_gnt_i) g++;
      if (g == 2) break;
    end
    @(negedge clk);
    tcdm_gnt_i = 1'b0;
    #1;
    total_n++; if (g != 2 || tcdm_req_o !== 1'b1) $display("FAIL t5_pending got=g%0d/req%b want=2/1", g, tcdm_req_o); else pass_n++;
    clear_i = 1'b1;
    @(negedge clk);
    clear_i = 1'b0; stream_valid_i = 1'b0;
    #1;
    total_n++; if (tcdm_req_o !== 1'b0) $display("FAIL t5_req_dropped got=%b want=0", tcdm_req_o); else pass_n++;
    total_n++; if (ready_start_o !== 1'b1 || cnt_o !== 16'd0)
      $display("FAIL t5_idle got=ready%b/cnt%0d want=1/0", ready_start_o, cnt_o); else pass_n++;
    if (done_o) seen++;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1 if (done_o) seen++;
    end
    total_n++; if (seen != 0) $display("FAIL t5_no_done got=%0d want=0", seen); else pass_n++;
    run_xfer(32'h3000, 1, 1, 100, 100, 0, -1, 1'b0);
    total_n++; if (done_n != 1 || obs_addr.size() != 1 || obs_addr[0] !== 32'h3000 || obs_data[0] !== words[0])
      $display("FAIL t5_restart got=done%0d/writes%0d want=1/1 at 00003000", done_n, obs_addr.size()); else pass_n++;
    $display("test_clear_mid grants_before_clear=%0d", g);
  endtask

  task automatic test_overflow;
    run_xfer(32'h0000_8000, 5, 7, 100, 70, 0, -1, 1'b1);
    total_n++; if (acc_n != 5) $display("FAIL t6_accepted got=%0d want=5", acc_n); else pass_n++;
    total_n++; if (ready_over != 0) $display("FAIL t6_backpressure got=%0d want=0", ready_over); else pass_n++;
    total_n++; if (obs_addr.size() != 5 || done_n != 1 || post_cnt !== 16'd5)
      $display("FAIL t6_count got=writes%0d/done%0d/cnt%0d want=5/1/5", obs_addr.size(), done_n, post_cnt); else pass_n++;
    for (int i = 0; i < obs_addr.size() && i < 5; i++) begin
      total_n++;
      if (obs_addr[i] !== exp_addr(32'h8000, i) || obs_data[i] !== words[i])
        $display("FAIL t6_write%0d got=%h/%h want=%h/%h", i, obs_addr[i], obs_data[i], exp_addr(32'h8000, i), words[i]);
      else pass_n++;
    end
    $display("test_overflow size=5 avail=7 accepted=%0d", acc_n);
  endtask

  task automatic test_random;
    logic [31:0] base;
    int size;
    for (int t = 0; t < 8; t++) begin
      base = $urandom & 32'hFFFF_FFFC;
      if (t == 0) base = 32'hFFFF_FFF0;
      size = $urandom_range(12, 1);
      run_xfer(base, size, size + $urandom_range(3), $urandom_range(100, 30), $urandom_range(100, 30), 0, -1,
               $urandom_range(1) == 1);
      total_n++; if (obs_addr.size() != size || done_n != 1 || post_cnt !== 16'(size) || post_req !== 1'b0)
        $display("FAIL rnd%0d_count got=writes%0d/done%0d/cnt%0d want=%0d/1/%0d", t, obs_addr.size(), done_n, post_cnt, size, size);
      else pass_n++;
      total_n++; if (unstable != 0 || ready_over != 0)
        $display("FAIL rnd%0d_protocol got=unstable%0d/over%0d want=0/0", t, unstable, ready_over); else pass_n++;
      for (int i = 0; i < obs_addr.size() && i < size; i++) begin
        total_n++;
        if (obs_addr[i] !== exp_addr(base, i) || obs_data[i] !== words[i])
          $display("FAIL rnd%0d_write%0d got=%h/%h want=%h/%h", t, i, obs_addr[i], obs_data[i], exp_addr(base, i), words[i]);
        else pass_n++;
      end
      $display("test_random %0d base=%h size=%0d writes=%0d", t, base, size, obs_addr.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_zero();
    test_wrap();
    test_clear_mid();
    test_overflow();
    test_random();
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end

endmodule
